mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Pipeline boundary between the memory stage and register writeback.
- Registers the memory-stage result and selects the scalar writeback value (load data or ALU result).
- Assembles consecutive matrix-line load words (MtypeL beats) into one full matrix line for the matrix register file.
- Its `w_regs_data` output also feeds the memory stage's store-data forwarding path.

Parameters:
- LINE_WORDS, 4: 32-bit words per matrix line; must be ≥2.
- CNT_W, 2: width of the word counter; equals clog2(LINE_WORDS).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- me_valid  input  1  memory-stage instruction valid this cycle.
- me_mem_data  input  32  load data from the memory stage (already sign/zero-extended).
- me_alu_o  input  32  ALU result / address.
- me_rd  input  5  destination register index (scalar or matrix).
- me_reg_write  input  1  scalar register write enable.
- me_mem2reg  input  1  1 selects me_mem_data, 0 selects me_alu_o.
- me_mline_load  input  1  current beat is a matrix-line load word.
- stall  input  1  hold all state this cycle.
- flush  input  1  squash the entering instruction and abort a partial line.
- w_regs_data  output  32  scalar writeback data.
- w_rd  output  5  scalar writeback index.
- w_reg_write  output  1  scalar writeback enable.
- w_mline_data  output  32*LINE_WORDS  assembled line; word i is at bits [32*i+31:32*i].
- w_mline_rd  output  5  matrix destination index.
- w_mline_valid  output  1  one-cycle pulse when a full line is ready.
- mline_busy  output  1  partial line in progress (FSM in FILL).

Behaviour:
- **Reset.** All outputs are 0, FSM is IDLE, word_cnt is 0, line buffer is cleared.
- **Priority per rising edge:** rst > flush > stall > normal.
- **Scalar path (1-cycle latency).** Applies when me_valid=1, me_mline_load=0 and neither stall nor flush is asserted:
  - w_regs_data <= me_mem2reg ? me_mem_data : me_alu_o.
  - w_rd <= me_rd.
  - w_reg_write <= me_reg_write.
  - Otherwise, with no stall, w_reg_write <= 0 and the data/index registers hold.
- **Stall.**
  - All registers hold, including word_cnt, buffer and FSM.
  - w_reg_write holds its value; it is not re-pulsed into a second write, because the downstream register file write is idempotent.
  - w_mline_valid is forced to 0 during stall.
- **Flush.**
  - w_reg_write <= 0 and w_mline_valid <= 0.
  - FSM goes to IDLE and word_cnt <= 0.
  - The partial line is discarded; buffer contents are don't-care.
- **Matrix-line beats never write the scalar file:** w_reg_write <= 0 on such a beat.
- **FSM.**
  - **IDLE:**
    - A beat (me_valid & me_mline_load, no stall/flush) writes word 0 with me_mem_data.
    - w_mline_rd <= me_rd, word_cnt <= 1, go to FILL.
  - **FILL:**
    - Each beat writes word[word_cnt] and increments word_cnt.
    - me_rd on later beats is ignored.
    - A cycle with no beat holds state; bubbles are allowed between beats.
  - **Last word (word_cnt == LINE_WORDS-1 on a beat):**
    - Write the word, pulse w_mline_valid for exactly 1 cycle with the full line visible on w_mline_data.
    - word_cnt wraps to 0, go to IDLE.
  - **Scalar instruction arriving during FILL:** it is processed normally on the scalar path; the line stays partial and FILL is unchanged.
- **Output hold.** w_mline_data and w_mline_rd hold after the pulse until the next line's first beat overwrites word 0. Consumers must sample only on w_mline_valid.
- **Busy flag.** mline_busy = (state == FILL).

Test Plan:
- **Reset mid-line.** Reset after 2 of 4 beats (0x11, 0x22) → all outputs 0, mline_busy=0. A fresh 4-beat line A0..A3 → w_mline_valid pulse with data {A3,A2,A1,A0}.
- **Scalar path select.** Scalar load: me_mem2reg=1, me_mem_data=0xFFFFFF80, me_rd=5 → next cycle w_regs_data=0xFFFFFF80, w_rd=5, w_reg_write=1 for 1 cycle. Same with me_mem2reg=0, me_alu_o=0x1234 → w_regs_data=0x1234.
- **Line with bubble and interleaved scalar.**
  - Beats 0x10, 0x20, bubble, scalar ALU op (rd=3, 0x7), beats 0x30, 0x40, with me_rd=9 on beat 0.
  - Expect: the scalar writes normally; on the 4th beat, w_mline_valid=1, w_mline_rd=9, line {0x40,0x30,0x20,0x10}.
- **Stall during FILL.** Stall held 3 cycles while me_valid=1 carries beat 0x99 → word_cnt unchanged, no line write. After release, beat 0x99 is accepted as the next word once.
- **Flush during FILL.** Flush after 3 beats → mline_busy=0 next cycle, no pulse. The next 4 beats form a complete new line starting at word 0.
- **Flush + stall together.** Assert both with a scalar instruction present → flush wins: w_reg_write=0, state IDLE.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register. Selects the scalar writeback value
// and gathers consecutive matrix-line load beats into one full matrix line.
module mem_wb_stage #(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    me_valid,
  input  logic [31:0]             me_mem_data,
  input  logic [31:0]             me_alu_o,
  input  logic [4:0]              me_rd,
  input  logic                    me_reg_write,
  input  logic                    me_mem2reg,
  input  logic                    me_mline_load,
  input  logic                    stall,
  input  logic                    flush,
  output logic [31:0]             w_regs_data,
  output logic [4:0]              w_rd,
  output logic                    w_reg_write,
  output logic [32*LINE_WORDS-1:0] w_mline_data,
  output logic [4:0]              w_mline_rd,
  output logic                    w_mline_valid,
  output logic                    mline_busy
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               word_cnt_q, word_cnt_d;
  logic [LINE_WORDS-1:0][31:0]    line_q, line_d;
  logic [4:0]                     mline_rd_q, mline_rd_d;
  logic                           mline_valid_q, mline_valid_d;
  logic [31:0]                    regs_data_q, regs_data_d;
  logic [4:0]                     rd_q, rd_d;
  logic                           reg_write_q, reg_write_d;

  logic beat, scalar, last_word;

  assign beat      = me_valid & me_mline_load;
  assign scalar    = me_valid & ~me_mline_load;
  // Last word only exists in FILL: IDLE always starts at word 0 and LINE_WORDS >= 2.
  assign last_word = (state_q == FILL) && (word_cnt_q == CNT_W'(LINE_WORDS - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: flush aborts, stall freezes, beats advance
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (!stall && beat) begin
      if (state_q == IDLE)  state_d = FILL;
      else if (last_word)   state_d = IDLE;
    end
  end

  // FSM output: a line is partially assembled
  always_comb begin
    mline_busy = (state_q == FILL);
  end

  // Datapath next state: scalar select, line buffer fill, counter, pulse
  always_comb begin
    word_cnt_d    = word_cnt_q;
    line_d        = line_q;
    mline_rd_d    = mline_rd_q;
    mline_valid_d = 1'b0;
    regs_data_d   = regs_data_q;
    rd_d          = rd_q;
    reg_write_d   = reg_write_q;
    if (flush) begin
      reg_write_d = 1'b0;
      word_cnt_d  = '0;
    end else if (stall) begin
      // Write enable holds; the register file write is idempotent.
      reg_write_d = reg_write_q;
    end else begin
      reg_write_d = scalar & me_reg_write;
      if (scalar) begin
        regs_data_d = me_mem2reg ? me_mem_data : me_alu_o;
        rd_d        = me_rd;
      end
      if (beat) begin
        line_d[word_cnt_q] = me_mem_data;
        if (state_q == IDLE) mline_rd_d = me_rd;
        if (last_word) begin
          word_cnt_d    = '0;
          mline_valid_d = 1'b1;
        end else begin
          word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q    <= '0;
      line_q        <= '0;
      mline_rd_q    <= '0;
      mline_valid_q <= 1'b0;
      regs_data_q   <= '0;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
    end else begin
      word_cnt_q    <= word_cnt_d;
      line_q        <= line_d;
      mline_rd_q    <= mline_rd_d;
      mline_valid_q <= mline_valid_d;
      regs_data_q   <= regs_data_d;
      rd_q          <= rd_d;
      reg_write_q   <= reg_write_d;
    end
  end

  assign w_regs_data   = regs_data_q;
  assign w_rd          = rd_q;
  assign w_reg_write   = reg_write_q;
  assign w_mline_data  = line_q;
  assign w_mline_rd    = mline_rd_q;
  assign w_mline_valid = mline_valid_q;

endmodule
